// File: rtl/dcache_sram_arb.sv
// -----------------------------------------------------------------------------
// dcache_sram_arb
//
// Purpose:
//   Arbiter and tag-compare stage between the L1 data-cache clients (port 0 is
//   the miss handler, ports 1..NR_PORTS-1 are cache controllers) and the shared
//   way-banked tag/data/valid-dirty SRAMs. Port 0 always wins when it requests.
//   The remaining ports share the SRAMs under fixed priority (lowest index
//   wins) or, when DCACHE_ARB_RR_EN is defined, round-robin.
//   The winning port is registered so that the tag compare and the read-valid
//   strobe produced one cycle later are routed back to that port.
//
// Configuration macro:
//   DCACHE_ARB_RR_EN  defined   -> round-robin among ports 1..NR_PORTS-1
//                     undefined -> fixed priority, lowest index wins
//
// Handshake:
//   A port requests while its req_i way mask is non-zero and holds the request
//   until gnt_o for that port is high in the same cycle (0-cycle grant). A
//   request may be withdrawn before its grant without leaving any state. For a
//   granted read, rvalid_o for that port and hit_way_o/multi_hit_o are valid
//   exactly one cycle after the grant; a granted write produces neither.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i                 per-port way request mask (NR_PORTS*SET_ASSOC)
//   addr_i                per-port SRAM index (NR_PORTS*INDEX_WIDTH)
//   we_i                  per-port write enable (NR_PORTS)
//   wdata_i               per-port packed write word (NR_PORTS*WDATA_WIDTH)
//   be_i                  per-port packed enables (NR_PORTS*BE_WIDTH)
//   tag_i                 per-port compare tag, used the cycle after the grant
//   gnt_o                 one-hot (or zero) grant
//   rvalid_o              one-hot read-valid, cycle after a read grant
//   hit_way_o             way hit vector for the pending read
//   multi_hit_o           more than one way hit in the current compare
//   ram_req_o .. ram_be_o SRAM-side request of the winning port
//   ram_rtag_i            per-way read tag, cycle after request
//   ram_rvalid_i          per-way valid bit, cycle after request
// -----------------------------------------------------------------------------
module dcache_sram_arb #(
  parameter int NR_PORTS    = 4,
  parameter int SET_ASSOC   = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = 44,
  parameter int WDATA_WIDTH = 176,
  parameter int BE_WIDTH    = 25
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_PORTS*SET_ASSOC-1:0]    req_i,
  input  logic [NR_PORTS*INDEX_WIDTH-1:0]  addr_i,
  input  logic [NR_PORTS-1:0]              we_i,
  input  logic [NR_PORTS*WDATA_WIDTH-1:0]  wdata_i,
  input  logic [NR_PORTS*BE_WIDTH-1:0]     be_i,
  input  logic [NR_PORTS*TAG_WIDTH-1:0]    tag_i,
  output logic [NR_PORTS-1:0]              gnt_o,
  output logic [NR_PORTS-1:0]              rvalid_o,
  output logic [SET_ASSOC-1:0]             hit_way_o,
  output logic                             multi_hit_o,
  output logic [SET_ASSOC-1:0]             ram_req_o,
  output logic [INDEX_WIDTH-1:0]           ram_addr_o,
  output logic                             ram_we_o,
  output logic [WDATA_WIDTH-1:0]           ram_wdata_o,
  output logic [BE_WIDTH-1:0]              ram_be_o,
  input  logic [SET_ASSOC*TAG_WIDTH-1:0]   ram_rtag_i,
  input  logic [SET_ASSOC-1:0]             ram_rvalid_i
);

  localparam int SEL_W = $clog2(NR_PORTS);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [NR_PORTS-1:0]    w_port_req;
  logic                   w_win_found;
  logic [SEL_W-1:0]       w_win_idx;
  logic [NR_PORTS-1:0]    w_gnt;
  logic [TAG_WIDTH-1:0]   w_tag_sel;
  logic [SET_ASSOC-1:0]   w_hit_way;

  logic [SEL_W-1:0]       r_sel;
  logic                   r_rd_pend;
`ifdef DCACHE_ARB_RR_EN
  logic [SEL_W-1:0]       r_rr_ptr;
`endif

  // A port is requesting while any bit of its way mask is set.
  for (genvar p = 0; p < NR_PORTS; p++) begin : g_port_req
    assign w_port_req[p] = |req_i[p*SET_ASSOC +: SET_ASSOC];
  end

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef DCACHE_ARB_RR_EN
  // Port 0 preempts; otherwise search ports 1..NR_PORTS-1 starting at the
  // round-robin pointer, wrapping from NR_PORTS-1 back to 1 (never to 0).
  always_comb begin
    int c;
    c           = 0;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    if (w_port_req[0]) begin
      w_win_found = 1'b1;
    end else begin
      for (int i = 0; i < NR_PORTS - 1; i++) begin
        c = ((int'(r_rr_ptr) - 1 + i) % (NR_PORTS - 1)) + 1;
        if (!w_win_found && w_port_req[c]) begin
          w_win_found = 1'b1;
          w_win_idx   = SEL_W'(c);
        end
      end
    end
  end
`else
  // Fixed priority: the first requesting port in index order wins, which also
  // gives port 0 its absolute priority.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (!w_win_found && w_port_req[p]) begin
        w_win_found = 1'b1;
        w_win_idx   = SEL_W'(p);
      end
    end
  end
`endif

  always_comb begin
    w_gnt = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      w_gnt[p] = w_win_found && (w_win_idx == SEL_W'(p));
    end
  end

  assign gnt_o = w_gnt;

  // ---------------------------------------------------------------------------
  // SRAM request mux: the grant is one-hot, so an AND-OR mux suffices and
  // yields all-zero outputs when nobody is granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_req_o   = '0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (w_gnt[p]) begin
        ram_req_o   = ram_req_o   | req_i[p*SET_ASSOC +: SET_ASSOC];
        ram_addr_o  = ram_addr_o  | addr_i[p*INDEX_WIDTH +: INDEX_WIDTH];
        ram_we_o    = ram_we_o    | we_i[p];
        ram_wdata_o = ram_wdata_o | wdata_i[p*WDATA_WIDTH +: WDATA_WIDTH];
        ram_be_o    = ram_be_o    | be_i[p*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered grant state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sel     <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      // ram_we_o is the winner's write enable (0 when idle).
      r_rd_pend <= w_win_found & ~ram_we_o;
      if (w_win_found) begin
        r_sel <= w_win_idx;
      end
    end
  end

`ifdef DCACHE_ARB_RR_EN
  // Pointer moves past a granted port k>=1; port-0 grants leave it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= SEL_W'(1);
    end else if (w_win_found && (w_win_idx != '0)) begin
      if (w_win_idx == SEL_W'(NR_PORTS - 1)) begin
        r_rr_ptr <= SEL_W'(1);
      end else begin
        r_rr_ptr <= w_win_idx + SEL_W'(1);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Compare stage, driven by the registered winner so that a new grant in the
  // same cycle does not disturb the compare of the previous one.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tag_sel = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (r_sel == SEL_W'(p)) begin
        w_tag_sel = tag_i[p*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_comb begin
    w_hit_way = '0;
    for (int w = 0; w < SET_ASSOC; w++) begin
      w_hit_way[w] = r_rd_pend & ram_rvalid_i[w] &
                     (ram_rtag_i[w*TAG_WIDTH +: TAG_WIDTH] == w_tag_sel);
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      rvalid_o[p] = r_rd_pend && (r_sel == SEL_W'(p));
    end
  end

  assign hit_way_o = w_hit_way;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign multi_hit_o = |(w_hit_way & (w_hit_way - {{(SET_ASSOC-1){1'b0}}, 1'b1}));

endmodule

// File: tb/tb_dcache_sram_arb.sv
// -----------------------------------------------------------------------------
// tb_dcache_sram_arb
//
// Directed bench for dcache_sram_arb with the default parameters
// (4 ports, 8 ways). Expected values are hand-computed constants; the
// arbitration sequence follows DCACHE_ARB_RR_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_dcache_sram_arb;

  localparam int NP = 4;
  localparam int SA = 8;
  localparam int IW = 12;
  localparam int TW = 44;
  localparam int DW = 176;
  localparam int BW = 25;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [NP*SA-1:0] req;
  logic [NP*IW-1:0] addr;
  logic [NP-1:0]    we;
  logic [NP*DW-1:0] wdata;
  logic [NP*BW-1:0] be;
  logic [NP*TW-1:0] tag;
  logic [NP-1:0]    gnt;
  logic [NP-1:0]    rvalid;
  logic [SA-1:0]    hit_way;
  logic             multi_hit;
  logic [SA-1:0]    ram_req;
  logic [IW-1:0]    ram_addr;
  logic             ram_we;
  logic [DW-1:0]    ram_wdata;
  logic [BW-1:0]    ram_be;
  logic [SA*TW-1:0] ram_rtag;
  logic [SA-1:0]    ram_rvalid;

  dcache_sram_arb #(
    .NR_PORTS(NP), .SET_ASSOC(SA), .INDEX_WIDTH(IW),
    .TAG_WIDTH(TW), .WDATA_WIDTH(DW), .BE_WIDTH(BW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
    .tag_i(tag),
    .gnt_o(gnt), .rvalid_o(rvalid), .hit_way_o(hit_way),
    .multi_hit_o(multi_hit),
    .ram_req_o(ram_req), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
    .ram_wdata_o(ram_wdata), .ram_be_o(ram_be),
    .ram_rtag_i(ram_rtag), .ram_rvalid_i(ram_rvalid)
  );

  // ---------------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req = '0;
    we  = '0;
  endtask

  task automatic drive_rd(input int p, input logic [SA-1:0] m,
                          input logic [IW-1:0] a);
    req[p*SA +: SA] = m;
    addr[p*IW +: IW] = a;
    we[p] = 1'b0;
  endtask

  task automatic drive_wr(input int p, input logic [IW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
    req[p*SA +: SA] = 8'hFF;
    addr[p*IW +: IW] = a;
    we[p] = 1'b1;
    wdata[p*DW +: DW] = d;
    be[p*BW +: BW] = b;
  endtask

  task automatic set_way(input int w, input logic [TW-1:0] t, input logic v);
    ram_rtag[w*TW +: TW] = t;
    ram_rvalid[w] = v;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  localparam logic [TW-1:0] T0 = 44'hABC_1234_5678;
  localparam logic [TW-1:0] T1 = 44'h123_0000_BEEF;
  localparam logic [TW-1:0] T2 = 44'hFED_CBA9_8765;
  localparam logic [DW-1:0] WD = {4{44'hA5A_5A5A_5A5A}};

  logic [NP-1:0] exp_g;
  logic [NP-1:0] prev_g;

  initial begin
    req = '0; addr = '0; we = '0; wdata = '0; be = '0; tag = '0;
    ram_rtag = '0; ram_rvalid = '0;

    // Reset with every port requesting reads; matching tags on all ways.
    rst = 1'b1;
    for (int p = 0; p < NP; p++) drive_rd(p, 8'hFF, IW'(p));
    for (int w = 0; w < SA; w++) set_way(w, '0, 1'b1);
    #2;
    chk("rst_gnt", gnt, 4'b0001);
    chk("rst_rvalid", rvalid, 4'b0000);
    chk("rst_hit", hit_way, 8'h00);
    step();
    chk("rst_rvalid_clk", rvalid, 4'b0000);
    chk("rst_multi", multi_hit, 1'b0);
    clear_reqs();
    rst = 1'b0;
    ram_rvalid = '0;

    // Port-0 preemption over port 2, then hit on way 3.
    step();
    drive_rd(0, 8'hFF, 12'h05A);
    drive_rd(2, 8'h0F, 12'h123);
    #2;
    chk("pre_gnt", gnt, 4'b0001);
    chk("pre_addr", ram_addr, 12'h05A);
    chk("pre_req", ram_req, 8'hFF);
    chk("pre_we", ram_we, 1'b0);
    step();
    clear_reqs();
    tag[0*TW +: TW] = T0;
    tag[2*TW +: TW] = T2;
    set_way(3, T0, 1'b1);
    set_way(5, T0, 1'b0);  // matching tag but invalid
    #2;
    chk("pre_hit", hit_way, 8'h08);
    chk("pre_rvalid", rvalid, 4'b0001);
    chk("pre_multi", multi_hit, 1'b0);
    chk("idle_gnt", gnt, 4'b0000);
    chk("idle_ram_req", ram_req, 8'h00);
    step();
    chk("post_rd_rvalid", rvalid, 4'b0000);
    ram_rtag = '0; ram_rvalid = '0;

    // Multi-hit: port 1 read, ways 1 and 5 match, way 2 valid with other tag.
    drive_rd(1, 8'h22, 12'h300);
    #2;
    chk("mh_gnt", gnt, 4'b0010);
    chk("mh_addr", ram_addr, 12'h300);
    step();
    clear_reqs();
    tag[1*TW +: TW] = T1;
    set_way(1, T1, 1'b1);
    set_way(2, T2, 1'b1);
    set_way(5, T1, 1'b1);
    #2;
    chk("mh_hit", hit_way, 8'h22);
    chk("mh_multi", multi_hit, 1'b1);
    chk("mh_rvalid", rvalid, 4'b0010);
    step();
    ram_rtag = '0; ram_rvalid = '0;

    // Miss: port 3 read with all ways invalid.
    drive_rd(3, 8'h01, 12'hFFF);
    #2;
    chk("miss_gnt", gnt, 4'b1000);
    step();
    clear_reqs();
    tag[3*TW +: TW] = '0;   // equals the zero tags, but nothing is valid
    #2;
    chk("miss_hit", hit_way, 8'h00);
    chk("miss_rvalid", rvalid, 4'b1000);
    chk("miss_multi", multi_hit, 1'b0);
    step();

    // Write from port 2 with all enables.
    drive_wr(2, 12'h0AB, WD, {BW{1'b1}});
    #2;
    chk("wr_gnt", gnt, 4'b0100);
    chk("wr_we", ram_we, 1'b1);
    chk("wr_wdata", ram_wdata, WD);
    chk("wr_be", ram_be, {BW{1'b1}});
    chk("wr_addr", ram_addr, 12'h0AB);
    step();
    clear_reqs();
    for (int w = 0; w < SA; w++) set_way(w, T2, 1'b1);
    #2;
    chk("wr_rvalid", rvalid, 4'b0000);
    chk("wr_hit", hit_way, 8'h00);
    chk("wr_idle_we", ram_we, 1'b0);
    step();
    ram_rtag = '0; ram_rvalid = '0;

    // Back-to-back: port 1 read then port 2 read; compare follows sel_q.
    tag[1*TW +: TW] = T1;
    tag[2*TW +: TW] = T2;
    drive_rd(1, 8'hFF, 12'h010);
    #2;
    chk("b2b_gnt1", gnt, 4'b0010);
    step();
    clear_reqs();
    drive_rd(2, 8'hFF, 12'h020);
    set_way(4, T1, 1'b1);
    #2;
    chk("b2b_gnt2", gnt, 4'b0100);
    chk("b2b_rvalid1", rvalid, 4'b0010);
    chk("b2b_hit1", hit_way, 8'h10);
    step();
    clear_reqs();
    ram_rtag = '0; ram_rvalid = '0;
    set_way(6, T2, 1'b1);
    #2;
    chk("b2b_rvalid2", rvalid, 4'b0100);
    chk("b2b_hit2", hit_way, 8'h40);
    step();
    ram_rtag = '0; ram_rvalid = '0;

    // Reset in the cycle after a read grant suppresses the compare.
    drive_rd(1, 8'hFF, 12'h040);
    step();
    clear_reqs();
    set_way(0, T1, 1'b1);
    #2;
    chk("rstmid_pre_rvalid", rvalid, 4'b0010);
    rst = 1'b1;
    #1;
    chk("rstmid_rvalid", rvalid, 4'b0000);
    chk("rstmid_hit", hit_way, 8'h00);
    rst = 1'b0;
    step();
    chk("rstmid_after", rvalid, 4'b0000);
    ram_rtag = '0; ram_rvalid = '0;

    // Arbitration: ports 1..3 request reads continuously.
    drive_rd(1, 8'hFF, 12'h101);
    drive_rd(2, 8'hFF, 12'h102);
    drive_rd(3, 8'hFF, 12'h103);
    prev_g = '0;
    for (int c = 0; c < 4; c++) begin
`ifdef DCACHE_ARB_RR_EN
      case (c)
        0:       exp_g = 4'b0010;
        1:       exp_g = 4'b0100;
        2:       exp_g = 4'b1000;
        default: exp_g = 4'b0010;
      endcase
`else
      exp_g = 4'b0010;
`endif
      #2;
      chk($sformatf("arb_gnt_%0d", c), gnt, exp_g);
      if (c > 0) chk($sformatf("arb_rvalid_%0d", c), rvalid, prev_g);
      prev_g = exp_g;
      step();
    end

    // One-cycle port-0 insertion; the sequence afterwards resumes unchanged.
    drive_rd(0, 8'h01, 12'h100);
    #2;
    chk("arb_p0_gnt", gnt, 4'b0001);
    chk("arb_p0_rvalid", rvalid, prev_g);
    step();
    req[0 +: SA] = '0;
    for (int c = 0; c < 2; c++) begin
`ifdef DCACHE_ARB_RR_EN
      exp_g = (c == 0) ? 4'b0100 : 4'b1000;
`else
      exp_g = 4'b0010;
`endif
      #2;
      chk($sformatf("arb_post_gnt_%0d", c), gnt, exp_g);
      step();
    end
    clear_reqs();
    #2;
    chk("final_gnt", gnt, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
